// File: rtl/fir_pkg.sv
// Shared types and default sizing for the FIR coefficient loader slice.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_FIN
    } state_t;

    localparam int unsigned DEF_COE_WIDTH     = 16;
    localparam int unsigned DEF_COE_TAPS      = 22;
    localparam int unsigned DEF_COE_SEL_WIDTH = 2;
    localparam int unsigned DEF_ADDR_WIDTH    = 5;
    localparam int unsigned DEF_RELOAD_INDEX  = 3;

endpackage

// File: rtl/fir_coe_stage_ram.sv
// Coefficient staging buffer: COE_TAPS words, synchronous write, combinational read.
module fir_coe_stage_ram #(
    parameter int unsigned COE_WIDTH  = fir_pkg::DEF_COE_WIDTH,
    parameter int unsigned COE_TAPS   = fir_pkg::DEF_COE_TAPS,
    parameter int unsigned ADDR_WIDTH = fir_pkg::DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [COE_WIDTH-1:0]  wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [COE_WIDTH-1:0]  rd_data
);
    import fir_pkg::*;

    localparam logic [ADDR_WIDTH:0] TAPS_W = (ADDR_WIDTH+1)'(COE_TAPS);

    logic [COE_WIDTH-1:0] mem [COE_TAPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < COE_TAPS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Addresses past the last tap read as zero rather than off the end of the array.
    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < TAPS_W) begin
            rd_data = mem[rd_addr];
        end
    end

endmodule

// File: rtl/fir_coe_loader.sv
// Host-side coefficient reload / bank-select driver for fir_top.
// Optional: FIR_COE_LOADER_AUTO_SEL_EN selects RELOAD_INDEX in the FIN cycle.
module fir_coe_loader #(
    parameter int unsigned COE_WIDTH     = fir_pkg::DEF_COE_WIDTH,
    parameter int unsigned COE_TAPS      = fir_pkg::DEF_COE_TAPS,
    parameter int unsigned COE_SEL_WIDTH = fir_pkg::DEF_COE_SEL_WIDTH,
    parameter int unsigned ADDR_WIDTH    = fir_pkg::DEF_ADDR_WIDTH,
    parameter int unsigned RELOAD_INDEX  = fir_pkg::DEF_RELOAD_INDEX
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld_i,
    input  logic [ADDR_WIDTH-1:0]    wr_addr_i,
    input  logic [COE_WIDTH-1:0]     wr_data_i,
    input  logic                     commit_i,
    input  logic                     sel_req_vld_i,
    input  logic [COE_SEL_WIDTH-1:0] sel_req_index_i,
    input  logic                     err_clr_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic                     coe_reload_vld_o,
    output logic [COE_WIDTH-1:0]     coe_reload_data_o,
    output logic                     coe_sel_vld_o,
    output logic [COE_SEL_WIDTH-1:0] coe_sel_index_o
);
    import fir_pkg::*;

    localparam logic [ADDR_WIDTH:0]    TAPS_W   = (ADDR_WIDTH+1)'(COE_TAPS);
    localparam logic [COE_SEL_WIDTH-1:0] AUTO_IDX = COE_SEL_WIDTH'(RELOAD_INDEX);
`ifdef FIR_COE_LOADER_AUTO_SEL_EN
    localparam bit AUTO_SEL = 1'b1;
`else
    localparam bit AUTO_SEL = 1'b0;
`endif

    state_t                   state, state_nxt;
    logic [ADDR_WIDTH:0]      cnt, cnt_nxt;
    logic                     pend_vld, pend_vld_nxt;
    logic [COE_SEL_WIDTH-1:0] pend_idx, pend_idx_nxt;
    logic                     busy_nxt, done_nxt, err_nxt;
    logic                     reload_vld_nxt;
    logic [COE_WIDTH-1:0]     reload_data_nxt;
    logic                     sel_vld_nxt;
    logic [COE_SEL_WIDTH-1:0] sel_idx_nxt;

    logic                     idle;
    logic                     addr_ok;
    logic                     wr_en;
    logic                     err_set;
    logic [ADDR_WIDTH-1:0]    rd_addr;
    logic [COE_WIDTH-1:0]     rd_data;

    assign idle    = (state == ST_IDLE);
    assign addr_ok = ({1'b0, wr_addr_i} < TAPS_W);
    assign wr_en   = wr_vld_i && idle && addr_ok;
    assign err_set = (wr_vld_i && !(idle && addr_ok)) || (commit_i && !idle);
    assign rd_addr = (state == ST_SEND) ? cnt[ADDR_WIDTH-1:0] : '0;

    fir_coe_stage_ram #(
        .COE_WIDTH  (COE_WIDTH),
        .COE_TAPS   (COE_TAPS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr_i),
        .wr_data (wr_data_i),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            pend_vld          <= 1'b0;
            pend_idx          <= '0;
            busy_o            <= 1'b0;
            done_o            <= 1'b0;
            err_o             <= 1'b0;
            coe_reload_vld_o  <= 1'b0;
            coe_reload_data_o <= '0;
            coe_sel_vld_o     <= 1'b0;
            coe_sel_index_o   <= '0;
        end else begin
            state             <= state_nxt;
            cnt               <= cnt_nxt;
            pend_vld          <= pend_vld_nxt;
            pend_idx          <= pend_idx_nxt;
            busy_o            <= busy_nxt;
            done_o            <= done_nxt;
            err_o             <= err_nxt;
            coe_reload_vld_o  <= reload_vld_nxt;
            coe_reload_data_o <= reload_data_nxt;
            coe_sel_vld_o     <= sel_vld_nxt;
            coe_sel_index_o   <= sel_idx_nxt;
        end
    end

    // cnt holds the index of the next word to put on the bus.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        pend_vld_nxt    = pend_vld;
        pend_idx_nxt    = pend_idx;
        done_nxt        = 1'b0;
        reload_vld_nxt  = 1'b0;
        reload_data_nxt = '0;
        sel_vld_nxt     = 1'b0;
        sel_idx_nxt     = '0;

        case (state)
            ST_IDLE: begin
                if (commit_i) begin
                    state_nxt      = ST_SEND;
                    cnt_nxt        = (ADDR_WIDTH+1)'(1);
                    reload_vld_nxt = 1'b1;
                    // A same-cycle write to tap 0 has not reached the array yet.
                    reload_data_nxt = (wr_en && wr_addr_i == '0) ? wr_data_i : rd_data;
                    // A select arriving with the commit would land on the first reload word.
                    if (sel_req_vld_i) begin
                        pend_vld_nxt = 1'b1;
                        pend_idx_nxt = sel_req_index_i;
                    end
                end else if (sel_req_vld_i) begin
                    sel_vld_nxt = 1'b1;
                    sel_idx_nxt = sel_req_index_i;
                end
            end

            ST_SEND: begin
                if (sel_req_vld_i) begin
                    pend_vld_nxt = 1'b1;
                    pend_idx_nxt = sel_req_index_i;
                end
                if (cnt == TAPS_W) begin
                    state_nxt = ST_FIN;
                    done_nxt  = 1'b1;
                    if (AUTO_SEL) begin
                        sel_vld_nxt = 1'b1;
                        sel_idx_nxt = AUTO_IDX;
                    end
                end else begin
                    reload_vld_nxt  = 1'b1;
                    reload_data_nxt = rd_data;
                    cnt_nxt         = cnt + 1'b1;
                end
            end

            ST_FIN: begin
                state_nxt    = ST_IDLE;
                cnt_nxt      = '0;
                pend_vld_nxt = 1'b0;
                pend_idx_nxt = '0;
                // The pending select lands in the first IDLE cycle; a FIN-cycle request is newest.
                if (sel_req_vld_i) begin
                    sel_vld_nxt = 1'b1;
                    sel_idx_nxt = sel_req_index_i;
                end else if (pend_vld) begin
                    sel_vld_nxt = 1'b1;
                    sel_idx_nxt = pend_idx;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);

        err_nxt = err_o;
        if (err_clr_i) begin
            err_nxt = 1'b0;
        end else if (err_set) begin
            err_nxt = 1'b1;
        end
    end

endmodule
